// File: rtl/serial_bcs_comparator.sv
// serial_bcs_comparator
// Bit-serial magnitude comparator. One bit comparator slice is reused once
// per clock, walking the operands MSB-first with the chain state (e, g)
// held in registers between steps. Operands arrive over a valid/ready
// handshake and the eq/gt/lt result, plus the number of bit positions
// examined, leaves over a second valid/ready handshake.

module serial_bcs_comparator #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1,
    localparam int CW        = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             eq,
    output logic             gt,
    output logic             lt,
    output logic [CW-1:0]    cycles
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] aShift_q;
    logic [WIDTH-1:0] bShift_q;
    logic             e_q;
    logic             g_q;
    logic [CW-1:0]    count_q;
    logic             outValid_q;
    logic             eq_q;
    logic             gt_q;
    logic             lt_q;
    logic [CW-1:0]    cycles_q;

    logic             ai;
    logic             bi;
    logic             e_d;
    logic             g_d;
    logic [CW-1:0]    count_d;
    logic             lastBit;
    logic             stopScan;

    // The current bit always sits in the MSB of the shift registers, so the
    // slice only ever looks at the top bit; count_q doubles as the bit index.
    always_comb begin
        ai       = aShift_q[WIDTH-1];
        bi       = bShift_q[WIDTH-1];
        e_d      = e_q & ~(ai ^ bi);
        g_d      = g_q | (e_q & ai & ~bi);
        count_d  = count_q + 1'b1;
        lastBit  = (count_q == CW'(WIDTH - 1));
        stopScan = lastBit | (EARLY_EXIT & ~e_d);
    end

    // Control FSM with the datapath registers; the result is captured on the
    // edge that leaves SHIFT so it stays frozen for the whole DONE period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            aShift_q   <= '0;
            bShift_q   <= '0;
            e_q        <= 1'b1;
            g_q        <= 1'b0;
            count_q    <= '0;
            outValid_q <= 1'b0;
            eq_q       <= 1'b0;
            gt_q       <= 1'b0;
            lt_q       <= 1'b0;
            cycles_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        aShift_q <= a;
                        bShift_q <= b;
                        e_q      <= 1'b1;
                        g_q      <= 1'b0;
                        count_q  <= '0;
                        state_q  <= SHIFT;
                    end
                end
                SHIFT: begin
                    aShift_q <= aShift_q << 1;
                    bShift_q <= bShift_q << 1;
                    e_q      <= e_d;
                    g_q      <= g_d;
                    count_q  <= count_d;
                    if (stopScan) begin
                        eq_q       <= e_d;
                        gt_q       <= g_d;
                        lt_q       <= ~e_d & ~g_d;
                        cycles_q   <= count_d;
                        outValid_q <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        outValid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Output mapping; in_ready follows the state so it rises as soon as reset
    // forces IDLE.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = outValid_q;
        eq        = eq_q;
        gt        = gt_q;
        lt        = lt_q;
        cycles    = cycles_q;
    end

endmodule

// File: tb/tb_serial_bcs_comparator.sv
// tb_serial_bcs_comparator
// Four comparator instances share one clock and reset:
//   0: WIDTH=8 EARLY_EXIT=1   1: WIDTH=8 EARLY_EXIT=0
//   2: WIDTH=4 EARLY_EXIT=1   3: WIDTH=4 EARLY_EXIT=0
// Directed vectors come from a table, followed by reset and exhaustive
// 4-bit sequences.

module tb_serial_bcs_comparator;

    logic        clk;
    logic        reset;
    logic        inValid  [4];
    logic        inReady  [4];
    logic [7:0]  aIn      [4];
    logic [7:0]  bIn      [4];
    logic        outValid [4];
    logic        outReady [4];
    logic        eqOut    [4];
    logic        gtOut    [4];
    logic        ltOut    [4];
    logic [7:0]  cycOut   [4];

    logic [3:0]  cyc0;
    logic [3:0]  cyc1;
    logic [2:0]  cyc2;
    logic [2:0]  cyc3;

    int nChecks = 0;
    int nFails  = 0;

    typedef struct {
        int          dut;
        logic [7:0]  a;
        logic [7:0]  b;
        int          hold;
        logic        eq;
        logic        gt;
        logic        lt;
        int          cyc;
        int          lat;
        string       tag;
    } vec_t;

    vec_t vecs[$];

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    serial_bcs_comparator #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut0 (
        .clk(clk), .reset(reset),
        .in_valid(inValid[0]), .in_ready(inReady[0]),
        .a(aIn[0]), .b(bIn[0]),
        .out_valid(outValid[0]), .out_ready(outReady[0]),
        .eq(eqOut[0]), .gt(gtOut[0]), .lt(ltOut[0]), .cycles(cyc0)
    );

    serial_bcs_comparator #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut1 (
        .clk(clk), .reset(reset),
        .in_valid(inValid[1]), .in_ready(inReady[1]),
        .a(aIn[1]), .b(bIn[1]),
        .out_valid(outValid[1]), .out_ready(outReady[1]),
        .eq(eqOut[1]), .gt(gtOut[1]), .lt(ltOut[1]), .cycles(cyc1)
    );

    serial_bcs_comparator #(.WIDTH(4), .EARLY_EXIT(1'b1)) dut2 (
        .clk(clk), .reset(reset),
        .in_valid(inValid[2]), .in_ready(inReady[2]),
        .a(aIn[2][3:0]), .b(bIn[2][3:0]),
        .out_valid(outValid[2]), .out_ready(outReady[2]),
        .eq(eqOut[2]), .gt(gtOut[2]), .lt(ltOut[2]), .cycles(cyc2)
    );

    serial_bcs_comparator #(.WIDTH(4), .EARLY_EXIT(1'b0)) dut3 (
        .clk(clk), .reset(reset),
        .in_valid(inValid[3]), .in_ready(inReady[3]),
        .a(aIn[3][3:0]), .b(bIn[3][3:0]),
        .out_valid(outValid[3]), .out_ready(outReady[3]),
        .eq(eqOut[3]), .gt(gtOut[3]), .lt(ltOut[3]), .cycles(cyc3)
    );

    assign cycOut[0] = {4'd0, cyc0};
    assign cycOut[1] = {4'd0, cyc1};
    assign cycOut[2] = {5'd0, cyc2};
    assign cycOut[3] = {5'd0, cyc3};

    // Single comparison point: every check funnels through here
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One full transaction on instance d: accept, latency count, result
    // check, optional backpressure with ignored in_valid, then release.
    task automatic applyStimulus(input int d, input logic [7:0] av, input logic [7:0] bv,
                                 input int hold, input logic expEq, input logic expGt,
                                 input logic expLt, input int expCyc, input int expLat,
                                 input string tag);
        int lat;
        int guard;
        @(negedge clk);
        guard = 0;
        while (!inReady[d] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput({tag, ".inReady"}, 64'(inReady[d]), 64'd1);
        aIn[d]      = av;
        bIn[d]      = bv;
        inValid[d]  = 1'b1;
        outReady[d] = (hold == 0);
        @(posedge clk);
        #1;
        inValid[d] = 1'b0;
        aIn[d]     = ~av;
        bIn[d]     = av;
        lat = 0;
        while (!outValid[d] && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput({tag, ".latency"}, 64'(lat), 64'(expLat));
        checkOutput({tag, ".eq"}, 64'(eqOut[d]), 64'(expEq));
        checkOutput({tag, ".gt"}, 64'(gtOut[d]), 64'(expGt));
        checkOutput({tag, ".lt"}, 64'(ltOut[d]), 64'(expLt));
        checkOutput({tag, ".cycles"}, 64'(cycOut[d]), 64'(expCyc));
        if (hold > 0) begin
            inValid[d] = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                checkOutput({tag, ".holdValid"}, 64'(outValid[d]), 64'd1);
                checkOutput({tag, ".holdReady"}, 64'(inReady[d]), 64'd0);
                checkOutput({tag, ".holdResult"},
                            {52'd0, eqOut[d], gtOut[d], ltOut[d], 1'b0, cycOut[d]},
                            {52'd0, expEq, expGt, expLt, 1'b0, 8'(expCyc)});
            end
            inValid[d]  = 1'b0;
            outReady[d] = 1'b1;
        end
        @(posedge clk);
        #1;
        checkOutput({tag, ".validDrop"}, 64'(outValid[d]), 64'd0);
        checkOutput({tag, ".readyBack"}, 64'(inReady[d]), 64'd1);
        outReady[d] = 1'b0;
    endtask

    // Watchdog so a stuck handshake can never hang the run
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence
    initial begin
        logic [3:0] ta;
        logic [3:0] tb;
        logic       mEq;
        logic       mGt;
        logic       mLt;
        int         j;
        bit         found;

        reset = 1'b0;
        for (int d = 0; d < 4; d++) begin
            inValid[d]  = 1'b0;
            outReady[d] = 1'b0;
            aIn[d]      = 8'd0;
            bIn[d]      = 8'd0;
        end

        #2;
        for (int d = 0; d < 4; d++) begin
            checkOutput($sformatf("reset%0d.state", d),
                        {58'd0, outValid[d], eqOut[d], gtOut[d], ltOut[d], inReady[d], 1'b0},
                        {58'd0, 5'b00001, 1'b0});
            checkOutput($sformatf("reset%0d.cycles", d), 64'(cycOut[d]), 64'd0);
        end
        #10 reset = 1'b1;

        vecs.push_back('{0, 8'hA5, 8'hA5, 0, 1'b1, 1'b0, 1'b0, 8, 8, "w8e_eq_A5"});
        vecs.push_back('{1, 8'hA5, 8'hA5, 1, 1'b1, 1'b0, 1'b0, 8, 8, "w8f_eq_A5"});
        vecs.push_back('{0, 8'h80, 8'h7F, 0, 1'b0, 1'b1, 1'b0, 1, 1, "w8e_gt_msb"});
        vecs.push_back('{1, 8'h80, 8'h7F, 0, 1'b0, 1'b1, 1'b0, 8, 8, "w8f_gt_msb"});
        vecs.push_back('{0, 8'h3C, 8'h3D, 0, 1'b0, 1'b0, 1'b1, 8, 8, "w8e_lt_lsb"});
        vecs.push_back('{1, 8'h3C, 8'h3D, 2, 1'b0, 1'b0, 1'b1, 8, 8, "w8f_lt_lsb"});
        vecs.push_back('{1, 8'h10, 8'h20, 0, 1'b0, 1'b0, 1'b1, 8, 8, "w8f_lt_bit5"});
        vecs.push_back('{2, 8'h09, 8'h06, 0, 1'b0, 1'b1, 1'b0, 1, 1, "w4e_gt_msb"});
        vecs.push_back('{3, 8'h09, 8'h06, 0, 1'b0, 1'b1, 1'b0, 4, 4, "w4f_gt_msb"});
        vecs.push_back('{2, 8'h02, 8'h03, 1, 1'b0, 1'b0, 1'b1, 4, 4, "w4e_lt_lsb"});
        vecs.push_back('{2, 8'h0B, 8'h09, 0, 1'b0, 1'b1, 1'b0, 3, 3, "w4e_gt_bit1"});
        vecs.push_back('{0, 8'h10, 8'h20, 5, 1'b0, 1'b0, 1'b1, 3, 3, "w8e_backpressure"});

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].dut, vecs[i].a, vecs[i].b, vecs[i].hold,
                          vecs[i].eq, vecs[i].gt, vecs[i].lt,
                          vecs[i].cyc, vecs[i].lat, vecs[i].tag);
        end

        // Reset pulse three bits into a scan on instance 0; the previous
        // result (lt=1, cycles=3) is still sitting in the output registers.
        @(negedge clk);
        aIn[0]     = 8'hFF;
        bIn[0]     = 8'hFE;
        inValid[0] = 1'b1;
        @(posedge clk);
        #1;
        inValid[0] = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        checkOutput("midReset.outValid", 64'(outValid[0]), 64'd0);
        checkOutput("midReset.flags", {61'd0, eqOut[0], gtOut[0], ltOut[0]}, 64'd0);
        checkOutput("midReset.cycles", 64'(cycOut[0]), 64'd0);
        checkOutput("midReset.inReady", 64'(inReady[0]), 64'd1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        applyStimulus(0, 8'h01, 8'h02, 0, 1'b0, 1'b0, 1'b1, 7, 7, "postReset_lt");

        // Every 4-bit operand pair on both early-exit settings
        for (int d = 2; d < 4; d++) begin
            for (int ai = 0; ai < 16; ai++) begin
                for (int bi = 0; bi < 16; bi++) begin
                    ta  = 4'(ai);
                    tb  = 4'(bi);
                    mEq = (ai == bi);
                    mGt = (ai > bi);
                    mLt = (ai < bi);
                    j     = 4;
                    found = 1'b0;
                    if (d == 2) begin
                        for (int k = 3; k >= 0; k--) begin
                            if (!found && (ta[k] != tb[k])) begin
                                j     = 4 - k;
                                found = 1'b1;
                            end
                        end
                    end
                    applyStimulus(d, {4'd0, ta}, {4'd0, tb}, int'($urandom_range(0, 2)),
                                  mEq, mGt, mLt, j, j,
                                  $sformatf("w4_d%0d_%0h_%0h", d, ai, bi));
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/serial_bcs_comparator.md
# serial_bcs_comparator

Bit-serial magnitude comparator built around the bit comparator slice (BCS) cascade: equal-in/greater-in chained MSB-first through a single registered slice, one bit per clock. Accepts two unsigned operands over a valid/ready handshake and returns eq/gt/lt plus the number of bits examined. Sits downstream of operand producers as the sequential, area-minimal counterpart to the combinational BCS chain.

## Interface

- WIDTH, 8, operand width in bits; legal range 2..64
- EARLY_EXIT, 1, 1 = stop at the first differing bit; 0 = always examine all WIDTH bits
- CW, $clog2(WIDTH+1), width of the cycles output (localparam, derived)

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; 0 forces the reset state immediately
- in_valid  in  1  operand pair present
- in_ready  out  1  block can accept operands (combinational: state == IDLE)
- a  in  WIDTH  operand A, unsigned, sampled on accept
- b  in  WIDTH  operand B, unsigned, sampled on accept
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result
- eq  out  1  a == b
- gt  out  1  a > b
- lt  out  1  a < b
- cycles  out  CW  number of bit positions processed

## Operation

- Slice equation per bit (ai, bi), chain state (e, g): e' = e & (ai ~^ bi); g' = g | (e & ai & ~bi). Chain initialised e=1, g=0 on accept.
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. in_valid=1 at an edge -> load a, b into shift registers, idx=WIDTH-1, e=1, g=0, count=0, go SHIFT.
- SHIFT: each edge applies the slice to bit idx, count+1, idx-1. Go DONE when idx was 0, or when EARLY_EXIT=1 and the new e=0. In_valid ignored.
- DONE entry registers eq=e, gt=g, lt=~e&~g, cycles=count, out_valid=1. Exactly one of eq/gt/lt is 1 while out_valid=1.
- DONE: outputs held stable while out_ready=0. out_ready=1 at an edge -> out_valid=0, go IDLE. eq/gt/lt/cycles keep last values after handshake (do not care while out_valid=0).
- No skid: next accept is at earliest the edge after the DONE->IDLE edge.

## Timing

- Reset (reset=0, any state, any time): state=IDLE, out_valid=0, eq=0, gt=0, lt=0, cycles=0; in_ready=1 while reset is low; in-flight operation discarded, no result produced.
- Accept at edge k. EARLY_EXIT=0: out_valid=1 after edge k+WIDTH, cycles=WIDTH.
- EARLY_EXIT=1: first differing bit at position j from MSB (1-based) -> out_valid=1 after edge k+j, cycles=j; equal operands -> k+WIDTH, cycles=WIDTH.
- Result accepted at edge m (out_valid & out_ready) -> in_ready=1 after edge m; earliest next accept edge m+1.
- Minimum throughput: one compare per WIDTH+2 cycles (full scan, out_ready held 1).
- out_ready=1 during IDLE/SHIFT has no effect. in_valid during SHIFT/DONE has no effect; producer holds its data.
- Reset release is asynchronous to clk; first accept allowed at the first edge with reset=1.

## Test plan

- WIDTH=8, EARLY_EXIT=1, a=0xA5, b=0xA5, out_ready=1 -> out_valid 8 cycles after accept, eq=1 gt=0 lt=0, cycles=8.
- WIDTH=8, EARLY_EXIT=1, a=0x80, b=0x7F -> out_valid 1 cycle after accept, gt=1, cycles=1; same with EARLY_EXIT=0 -> gt=1, cycles=8, 8 cycles after accept.
- WIDTH=8, a=0x3C, b=0x3D -> lt=1, cycles=8 (LSB decides, both EARLY_EXIT settings).
- Backpressure: a=0x10, b=0x20, out_ready=0 for 5 cycles after out_valid -> lt=1, cycles=3 held stable, in_ready=0, new in_valid ignored; out_ready=1 -> out_valid drops next edge, in_ready=1.
- Reset pulse low mid-SHIFT (3 bits into a=0xFF,b=0xFE) -> immediately out_valid=0, eq/gt/lt/cycles=0, in_ready=1; subsequent a=0x01,b=0x02 -> lt=1 with correct latency.
- WIDTH=4, both EARLY_EXIT values, all 256 (a,b) pairs back-to-back with random out_ready -> eq/gt/lt match integer comparison, cycles match latency rule, zero errors reported.
